// File: rtl/lsu_pkg.sv
// lsu_pkg: address map, region codes and byte-lane helpers for lsu_sync.
// Shared by lsu_sync and lsu_timer; LSU_TIMER_IRQ_EN selects the timer IRQ build.
package lsu_pkg;

    localparam logic [15:0] DMEM_BASE   = 16'h2000;
    localparam logic [15:0] TIMER_BASE  = 16'h4000;
    localparam logic [15:0] LEDR_ADDR   = 16'h7000;
    localparam logic [15:0] LEDG_ADDR   = 16'h7010;
    localparam logic [15:0] SEG_LO_ADDR = 16'h7020;
    localparam logic [15:0] SEG_HI_ADDR = 16'h7024;
    localparam logic [15:0] LCD_ADDR    = 16'h7030;
    localparam logic [15:0] SW_ADDR     = 16'h7800;
    localparam logic [15:0] BTN_ADDR    = 16'h7810;

    typedef enum logic [3:0] {
        RG_DMEM,
        RG_TIMER,
        RG_LEDR,
        RG_LEDG,
        RG_SEG7,
        RG_LCD,
        RG_SW,
        RG_BTN,
        RG_NONE
    } region_e;

    function automatic logic strb_legal(input logic [3:0] strb);
        case (strb)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/lsu_timer.sv
// lsu_timer: one timer channel, free-running COUNT with optional CMP reload.
// Compare/reload and match flag exist only when LSU_TIMER_IRQ_EN is defined.
module lsu_timer
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_count,
    input  logic        wr_cmp,
    input  logic [31:0] data,
    input  logic [3:0]  strb,
    output logic [31:0] count,
    output logic [31:0] cmp,
    output logic        match
);

`ifdef LSU_TIMER_IRQ_EN
    assign match = (count == cmp) && (cmp != 32'd0);

    // compare value, byte-writable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmp <= '0;
        end else if (wr_cmp) begin
            cmp <= byte_merge(cmp, data, strb);
        end
    end
`else
    logic unused_cmp;
    assign unused_cmp = wr_cmp;
    assign match = 1'b0;
    assign cmp = '0;
`endif

    // counter: a store beats a match reload, which beats the increment
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (wr_count) begin
            count <= byte_merge(count, data, strb);
        end else if (match) begin
            count <= '0;
        end else begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/lsu_sync.sv
// lsu_sync: load/store unit with block-RAM data memory and board MMIO.
// Fixed 1-cycle req/ack; define LSU_TIMER_IRQ_EN for timer compare/IRQ.
module lsu_sync
    import lsu_pkg::*;
#(
    parameter int DMEM_BYTES = 256,
    parameter int NUM_TIMERS = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_req,
    input  logic            i_wren,
    input  logic [31:0]     i_addr,
    input  logic [31:0]     i_st_data,
    input  logic [3:0]      i_st_strb,
    output logic            o_ack,
    output logic [31:0]     o_ld_data,
    output logic            o_err,
    input  logic [31:0]     i_io_sw,
    input  logic [3:0]      i_io_btn,
    output logic [31:0]     o_io_ledr,
    output logic [31:0]     o_io_ledg,
    output logic [7:0][6:0] o_io_hex,
    output logic [31:0]     o_io_lcd,
    output logic            o_lcd_vld,
    output logic            o_timer_irq
);

    localparam int WORDS = DMEM_BYTES / 4;
    localparam int IW = $clog2(WORDS);
    localparam logic [15:0] DMEM_END = DMEM_BASE + 16'(DMEM_BYTES);

    region_e rg;
    logic err, acc, st_ok, ld_ok;
    logic [31:0] rdata, tmr_rd;
    logic [31:0] ledr, ledg, seg_lo, seg_hi, lcd;
    logic ack, err_q, sel_ram, lcd_vld;
    logic [31:0] data_q, ram_q;
    logic [31:0] count [NUM_TIMERS];
    logic [31:0] cmp [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] match, wr_cnt, wr_cmp, status;
    logic [31:0] mem [WORDS];
    logic [63:0] seg;

    // address decode; word granularity, upper half must be zero
    always_comb begin
        rg = RG_NONE;
        if (i_addr[31:16] == 16'h0) begin
            if (i_addr[15:0] >= DMEM_BASE && i_addr[15:0] < DMEM_END) begin
                rg = RG_DMEM;
            end else if (i_addr[15:7] == TIMER_BASE[15:7]) begin
                if (!i_addr[6]) begin
                    if (32'(i_addr[5:3]) < 32'(NUM_TIMERS)) rg = RG_TIMER;
                end else if (i_addr[5:2] == 4'd0) begin
                    rg = RG_TIMER;
                end
            end else if (i_addr[15:2] == LEDR_ADDR[15:2]) begin
                rg = RG_LEDR;
            end else if (i_addr[15:2] == LEDG_ADDR[15:2]) begin
                rg = RG_LEDG;
            end else if (i_addr[15:2] == SEG_LO_ADDR[15:2]
                      || i_addr[15:2] == SEG_HI_ADDR[15:2]) begin
                rg = RG_SEG7;
            end else if (i_addr[15:2] == LCD_ADDR[15:2]) begin
                rg = RG_LCD;
            end else if (i_addr[15:2] == SW_ADDR[15:2]) begin
                rg = RG_SW;
            end else if (i_addr[15:2] == BTN_ADDR[15:2]) begin
                rg = RG_BTN;
            end
        end
    end

    assign err   = (rg == RG_NONE) || (i_wren && !strb_legal(i_st_strb));
    assign acc   = i_req && i_rst_n;
    assign st_ok = acc && i_wren && !err;
    assign ld_ok = acc && !i_wren && !err;

    for (genvar n = 0; n < NUM_TIMERS; n++) begin : g_tmr
        assign wr_cnt[n] = st_ok && rg == RG_TIMER && !i_addr[6]
                        && i_addr[5:3] == 3'(n) && !i_addr[2];
        assign wr_cmp[n] = st_ok && rg == RG_TIMER && !i_addr[6]
                        && i_addr[5:3] == 3'(n) && i_addr[2];
        lsu_timer u_tmr (
            .clk      (i_clk),
            .rst_n    (i_rst_n),
            .wr_count (wr_cnt[n]),
            .wr_cmp   (wr_cmp[n]),
            .data     (i_st_data),
            .strb     (i_st_strb),
            .count    (count[n]),
            .cmp      (cmp[n]),
            .match    (match[n])
        );
    end

`ifdef LSU_TIMER_IRQ_EN
    logic [NUM_TIMERS-1:0] clr, status_nxt;
    logic irq;
    assign clr = (st_ok && rg == RG_TIMER && i_addr[6])
               ? (i_st_data[NUM_TIMERS-1:0] & {NUM_TIMERS{i_st_strb[0]}})
               : '0;
    assign status_nxt = (status & ~clr) | match;

    // sticky match flags, write-1-to-clear, a new match beats the clear
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            status <= '0;
            irq <= 1'b0;
        end else begin
            status <= status_nxt;
            irq <= |status_nxt;
        end
    end
    assign o_timer_irq = irq;
`else
    logic unused_match;
    assign unused_match = ^match;
    assign status = '0;
    assign o_timer_irq = 1'b0;
`endif

    // timer window read: channel COUNT/CMP or STATUS
    always_comb begin
        tmr_rd = '0;
        for (int n = 0; n < NUM_TIMERS; n++) begin
            if (i_addr[5:3] == 3'(n)) tmr_rd = i_addr[2] ? cmp[n] : count[n];
        end
        if (i_addr[6]) tmr_rd = 32'(status);
    end

    // snapshot of the non-RAM load data
    always_comb begin
        case (rg)
            RG_TIMER: rdata = tmr_rd;
            RG_LEDR:  rdata = ledr;
            RG_LEDG:  rdata = ledg;
            RG_SEG7:  rdata = i_addr[2] ? seg_hi : seg_lo;
            RG_LCD:   rdata = lcd;
            RG_SW:    rdata = i_io_sw;
            RG_BTN:   rdata = {28'd0, i_io_btn};
            default:  rdata = '0;
        endcase
    end

    // data memory: byte-lane writes, registered read, contents not reset
    always_ff @(posedge i_clk) begin
        if (acc && rg == RG_DMEM && !err) begin
            if (i_wren) begin
                for (int b = 0; b < 4; b++) begin
                    if (i_st_strb[b]) mem[i_addr[IW+1:2]][8*b +: 8] <= i_st_data[8*b +: 8];
                end
            end else begin
                ram_q <= mem[i_addr[IW+1:2]];
            end
        end
    end

    // board output registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ledr <= '0;
            ledg <= '0;
            seg_lo <= '0;
            seg_hi <= '0;
            lcd <= '0;
        end else if (st_ok) begin
            case (rg)
                RG_LEDR: ledr <= byte_merge(ledr, i_st_data, i_st_strb);
                RG_LEDG: ledg <= byte_merge(ledg, i_st_data, i_st_strb);
                RG_SEG7: begin
                    if (i_addr[2]) seg_hi <= byte_merge(seg_hi, i_st_data, i_st_strb);
                    else seg_lo <= byte_merge(seg_lo, i_st_data, i_st_strb);
                end
                RG_LCD:  lcd <= byte_merge(lcd, i_st_data, i_st_strb);
                default: ;
            endcase
        end
    end

    // response stage, exactly one cycle after accept
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ack <= 1'b0;
            err_q <= 1'b0;
            sel_ram <= 1'b0;
            data_q <= '0;
            lcd_vld <= 1'b0;
        end else begin
            ack <= i_req;
            err_q <= i_req && err;
            sel_ram <= ld_ok && rg == RG_DMEM;
            data_q <= (ld_ok && rg != RG_DMEM) ? rdata : '0;
            lcd_vld <= st_ok && rg == RG_LCD;
        end
    end

    assign o_ack = ack;
    assign o_err = err_q;
    assign o_ld_data = sel_ram ? ram_q : data_q;
    assign o_lcd_vld = lcd_vld;
    assign o_io_ledr = ledr;
    assign o_io_ledg = ledg;
    assign o_io_lcd = lcd;
    assign seg = {seg_hi, seg_lo};

    for (genvar n = 0; n < 8; n++) begin : g_hex
        assign o_io_hex[n] = seg[8*n +: 7];
    end

    logic unused;
    assign unused = ^{i_addr[1:0], seg[63], seg[55], seg[47], seg[39],
                      seg[31], seg[23], seg[15], seg[7]};

endmodule
